sysid_verify_ctrl: RTL
======================

Name: sysid_verify_ctrl

Overview:
- Sequencer that reads the 2-word system-ID slave and checks it: word 0 is the ID, word 1 is the timestamp.
- Compares both words against build-time expected values and latches pass/fail status.
- Exposes results to the Nios II through a small 4-word Avalon-MM control/status slave.
- Runs once automatically after reset, and again whenever software requests it.

Parameters:
- EXPECTED_ID, 32'd0: value the ID word must match.
- EXPECTED_TS, 32'd1525092812: value the timestamp word must match.
- READ_LATENCY, 0: extra cycles to hold sid_address before sampling sid_readdata (0 suits a combinational slave). Legal range 0..15.
- AUTO_START, 1: when 1, a check starts in the first cycle after reset deasserts.

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- sid_address  out  1  word select to the system-ID slave
- sid_readdata  in  32  read data from the system-ID slave
- ctl_address  in  2  control slave word address
- ctl_read  in  1  control slave read strobe
- ctl_write  in  1  control slave write strobe
- ctl_writedata  in  32  control slave write data
- ctl_readdata  out  32  control slave read data, registered
- done  out  1  sticky "check complete"
- id_ok  out  1  high when the last completed check matched both words

Behaviour:
- Interface fixed: single clock `clock`; reset `reset_n` is synchronous and active-low. All state is updated only on the rising edge of `clock`.
- Reset values:
  - state IDLE (or RD_ID if AUTO_START=1 on the first cycle after release)
  - sid_address=0, ctl_readdata=0, done=0, id_ok=0
  - cap_id=0, cap_ts=0, match flags=0, run_count=0, latency counter=0
- FSM:
  - IDLE: start pending -> RD_ID.
  - RD_ID: sid_address=0; lat_cnt counts 0..READ_LATENCY. When lat_cnt==READ_LATENCY, capture cap_id<=sid_readdata and id_match<=(sid_readdata==EXPECTED_ID), clear lat_cnt -> RD_TS.
  - RD_TS: sid_address=1; same counting. At terminal count, capture cap_ts and ts_match -> DONE.
  - DONE (one cycle): done<=1, id_ok<=id_match&ts_match, run_count<=run_count+1 (8-bit, wraps 255->0) -> IDLE.
- Timing: busy lasts exactly 2*(READ_LATENCY+1) cycles. done rises on the edge after the DONE cycle.
- sid_address is a registered decode of state. It is 0 in IDLE and DONE.
- Start sources:
  - AUTO_START after reset.
  - A write to address 0 with bit0=1.
  - A start write while busy (RD_ID/RD_TS/DONE) is ignored; no queuing.
- When a new check starts: done, id_ok and both match flags clear in the same edge as entry to RD_ID. cap_id/cap_ts hold until overwritten.
- Write to address 0, bit1=1: clears done.
  - Same write with bit0=1 while IDLE: start wins, done ends cleared.
  - If that write coincides with the DONE cycle: the set wins, done=1.
- Writes to addresses 1..3 are ignored.
- Control read map. ctl_readdata updates on the edge after the ctl_read cycle (read latency 1) and holds otherwise:
  - 0: {26'b0, id_ok, ts_match, id_match, done, busy, 1'b0}, i.e. bit1=busy, bit2=done, bit3=id_match, bit4=ts_match, bit5=id_ok
  - 1: cap_id
  - 2: cap_ts
  - 3: {24'b0, run_count}
- Simultaneous ctl_read and ctl_write: both are serviced. Read data reflects state before the write.
- reset_n low mid-check: abort in the same edge, all values return to reset values. The partially captured word is discarded.

Test Plan:
- Reset release, AUTO_START=1, READ_LATENCY=0, slave returns 0/1525092812:
  - sid_address 0 then 1 for one cycle each.
  - done=1 and id_ok=1 three cycles after release.
  - Address 3 reads 1.
- Slave ID forced to 32'h0000_0001:
  - done=1, id_ok=0.
  - Status reads bit3=0, bit4=1.
  - Address 1 reads 1.
- READ_LATENCY=3, software start on address 0 (data 1):
  - Each sid_address phase lasts 4 cycles; busy bit set for 8 cycles.
  - Captures sampled only on the 4th cycle. Toggle sid_readdata in earlier cycles to prove they are ignored.
- Start written while busy, plus write 0x3 in the DONE cycle:
  - The extra start is ignored; run_count increments by exactly 1.
  - done=1 after the DONE cycle.
- Assert reset_n low in RD_TS: next cycle all outputs are 0 and cap_ts is unchanged from 0. After release with AUTO_START=1, a full check passes.
- 256 back-to-back software starts: run_count wraps to 0 and address 3 reads 0.

Source files
------------

// File: rtl/sysid_verify_ctrl.sv
// Reads the two-word system-ID slave (ID, then timestamp), compares both against
// build-time constants and reports the result through a 4-word control/status slave.
module sysid_verify_ctrl #(
  parameter logic [31:0] EXPECTED_ID  = 32'd0,
  parameter logic [31:0] EXPECTED_TS  = 32'd1525092812,
  parameter int unsigned READ_LATENCY = 0,
  parameter bit          AUTO_START   = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        sid_address,
  input  logic [31:0] sid_readdata,
  input  logic [1:0]  ctl_address,
  input  logic        ctl_read,
  input  logic        ctl_write,
  input  logic [31:0] ctl_writedata,
  output logic [31:0] ctl_readdata,
  output logic        done,
  output logic        id_ok
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RD_ID = 2'd1,
    S_RD_TS = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // With AUTO_START the reset state is already RD_ID, so the first post-reset
  // cycle is the first ID sample cycle.
  localparam state_e     RESET_STATE = AUTO_START ? S_RD_ID : S_IDLE;
  localparam logic [3:0] LAT_LAST    = 4'(READ_LATENCY);

  state_e      state_q;
  logic [3:0]  lat_cnt_q;
  logic        sid_address_q;
  logic [31:0] ctl_readdata_q;
  logic        done_q;
  logic        id_ok_q;
  logic        id_match_q;
  logic        ts_match_q;
  logic [31:0] cap_id_q;
  logic [31:0] cap_ts_q;
  logic [7:0]  run_count_q;

  logic        busy;
  logic        ctl_wr0;
  logic        start_req;
  logic        clr_req;
  logic [31:0] rd_data_d;
  logic        unused_wdata;

  assign busy         = (state_q == S_RD_ID) || (state_q == S_RD_TS);
  assign ctl_wr0      = ctl_write && (ctl_address == 2'd0);
  assign start_req    = ctl_wr0 && ctl_writedata[0];
  assign clr_req      = ctl_wr0 && ctl_writedata[1];
  assign unused_wdata = ^ctl_writedata[31:2];

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    rd_data_d = '0;
    case (ctl_address)
      2'd0: rd_data_d = {26'b0, id_ok_q, ts_match_q, id_match_q, done_q, busy, 1'b0};
      2'd1: rd_data_d = cap_id_q;
      2'd2: rd_data_d = cap_ts_q;
      2'd3: rd_data_d = {24'b0, run_count_q};
      default: rd_data_d = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q        <= RESET_STATE;
      lat_cnt_q      <= '0;
      sid_address_q  <= 1'b0;
      ctl_readdata_q <= '0;
      done_q         <= 1'b0;
      id_ok_q        <= 1'b0;
      id_match_q     <= 1'b0;
      ts_match_q     <= 1'b0;
      cap_id_q       <= '0;
      cap_ts_q       <= '0;
      run_count_q    <= '0;
    end else begin
      if (ctl_read) begin
        ctl_readdata_q <= rd_data_d;
      end

      // NOTE: non-blocking assignments make the last one in program order win,
      // so the DONE-state set below overrides this software clear.
      if (clr_req) begin
        done_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (start_req) begin
            state_q    <= S_RD_ID;
            lat_cnt_q  <= '0;
            done_q     <= 1'b0;
            id_ok_q    <= 1'b0;
            id_match_q <= 1'b0;
            ts_match_q <= 1'b0;
          end
        end
        S_RD_ID: begin
          if (lat_cnt_q == LAT_LAST) begin
            cap_id_q      <= sid_readdata;
            id_match_q    <= (sid_readdata == EXPECTED_ID);
            lat_cnt_q     <= '0;
            sid_address_q <= 1'b1;
            state_q       <= S_RD_TS;
          end else begin
            lat_cnt_q <= lat_cnt_q + 4'd1;
          end
        end
        S_RD_TS: begin
          if (lat_cnt_q == LAT_LAST) begin
            cap_ts_q      <= sid_readdata;
            ts_match_q    <= (sid_readdata == EXPECTED_TS);
            lat_cnt_q     <= '0;
            sid_address_q <= 1'b0;
            state_q       <= S_DONE;
          end else begin
            lat_cnt_q <= lat_cnt_q + 4'd1;
          end
        end
        S_DONE: begin
          done_q      <= 1'b1;
          id_ok_q     <= id_match_q && ts_match_q;
          run_count_q <= run_count_q + 8'd1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sid_address  = sid_address_q;
  assign ctl_readdata = ctl_readdata_q;
  assign done         = done_q;
  assign id_ok        = id_ok_q;

endmodule
